// File: rtl/apb_reg_slave.sv
// APB register slave: ID, wait-state config, transfer counter, scratch regs.
// Optional APB_SLV_PROT_CHECK_EN: unprivileged writes to WAIT_CFG are errored.
module apb_reg_slave #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] ID_VALUE   = 32'hA4B1_0001,
  parameter logic [3:0]  RESET_WAIT = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state;
  logic [3:0]            wait_cfg;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] access_cnt;
  logic [DATA_WIDTH-1:0] scratch [3:NUM_REGS-1];

  logic [IW-1:0]         a_idx;
  logic                  a_write;
  logic [DATA_WIDTH-1:0] a_data;
  logic [SW-1:0]         a_strb;
  logic                  a_err;
  logic [DATA_WIDTH-1:0] a_rd;

  logic [IW-1:0]         idx;
  logic                  in_range;
  logic                  aligned;
  logic                  is_ro;
  logic                  prot_err;
  logic                  err;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] rsp_rd;
  logic                  unused_prot;

  assign idx      = paddr[IW+1:2];
  assign in_range = paddr < ADDR_WIDTH'(NUM_REGS * 4);
  assign aligned  = paddr[1:0] == 2'b00;
  assign is_ro    = (idx == IW'(0)) || (idx == IW'(2));

`ifdef APB_SLV_PROT_CHECK_EN
  assign prot_err = pwrite && (idx == IW'(1)) && !pprot[0];
`else
  assign prot_err = 1'b0;
`endif
  assign unused_prot = ^pprot;

  assign err = !in_range || !aligned || (pwrite && is_ro) || prot_err;

  always_comb begin
    rd_val = '0;
    if (idx == IW'(0))
      rd_val = ID_VALUE;
    else if (idx == IW'(1))
      rd_val = DATA_WIDTH'(wait_cfg);
    else if (idx == IW'(2))
      rd_val = access_cnt;
    else if (in_range)
      rd_val = scratch[idx];
  end

  // Response is frozen at the setup edge; errored and write beats return 0.
  assign rsp_rd = (err || pwrite) ? '0 : rd_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prdata     <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      wait_cfg   <= RESET_WAIT;
      cnt        <= '0;
      access_cnt <= '0;
      a_idx      <= '0;
      a_write    <= 1'b0;
      a_data     <= '0;
      a_strb     <= '0;
      a_err      <= 1'b0;
      a_rd       <= '0;
      for (int i = 3; i < NUM_REGS; i++)
        scratch[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          if (psel && !penable) begin
            a_idx   <= idx;
            a_write <= pwrite;
            a_data  <= pwdata;
            a_strb  <= pstrb;
            a_err   <= err;
            a_rd    <= rsp_rd;
            if (wait_cfg == 4'd0) begin
              state   <= DONE;
              pready  <= 1'b1;
              pslverr <= err;
              prdata  <= rsp_rd;
            end else begin
              cnt   <= wait_cfg;
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            state   <= DONE;
            pready  <= 1'b1;
            pslverr <= a_err;
            prdata  <= a_rd;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          if (psel && penable) begin
            access_cnt <= access_cnt + DATA_WIDTH'(1);
            if (a_write && !a_err) begin
              if (a_idx == IW'(1)) begin
                if (a_strb[0])
                  wait_cfg <= a_data[3:0];
              end else if (a_idx >= IW'(3)) begin
                for (int b = 0; b < SW; b++)
                  if (a_strb[b])
                    scratch[a_idx][8*b +: 8] <= a_data[8*b +: 8];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: vector table, corner sequences,
// and randomized transfers against a behavioural register-map model.
module tb_apb_reg_slave;

  localparam int NREG = 8;
  localparam logic [31:0] ID = 32'hA4B1_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_wait;
  logic [31:0] m_cnt;
  logic [31:0] m_scr [NREG];

  apb_reg_slave dut (
    .clk     (clk),
    .rst     (rst),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .pprot   (pprot),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_wait = 0;
    m_cnt  = 0;
    for (int i = 0; i < NREG; i++) m_scr[i] = 0;
  endfunction

  // Register-map semantics expressed directly on addresses and words.
  task automatic model(input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [2:0] p, output logic [31:0] rd,
                       output logic er, output int ws);
    logic [31:0] cur;
    er = (a >= NREG * 4) || (a % 4 != 0) || (w && (a == 0 || a == 8));
`ifdef APB_SLV_PROT_CHECK_EN
    if (w && a == 4 && !p[0]) er = 1'b1;
`endif
    ws  = int'(m_wait);
    cur = 0;
    if (!er) begin
      if (a == 0) cur = ID;
      else if (a == 4) cur = m_wait;
      else if (a == 8) cur = m_cnt;
      else cur = m_scr[a / 4];
    end
    rd = (er || w) ? 32'h0 : cur;
    m_cnt = m_cnt + 1;
    if (w && !er) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
      if (a == 4) m_wait = cur & 32'hF;
      else m_scr[a / 4] = cur;
    end
  endtask

  // Entered and left at posedge+1; the next transfer may follow at once.
  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p, output logic [31:0] rd,
                      output logic er, output int ws);
    logic done;
    paddr = a; pwrite = w; pwdata = d; pstrb = s; pprot = p;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    ws = 0; rd = 0; er = 0; done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pready) begin
        rd = prdata; er = pslverr; done = 1;
        break;
      end
      ws++;
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout: no pready for addr %h", a);
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    if (done) chk("pready_pulse", {31'd0, pready}, 32'd0);
  endtask

  task automatic run(input string name, input logic [31:0] a,
                     input logic w, input logic [31:0] d,
                     input logic [3:0] s, input logic [2:0] p);
    logic [31:0] erd, ard;
    logic eer, aer;
    int ews, aws;
    model(a, w, d, s, p, erd, eer, ews);
    xfer(a, w, d, s, p, ard, aer, aws);
    chk({name, "_rdata"}, ard, erd);
    chk({name, "_err"}, {31'd0, aer}, {31'd0, eer});
    chk({name, "_waits"}, aws, ews);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_w;
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [31:0] ard, mrd;
    logic aer, mer, seen;
    int aws, mws;
    logic [31:0] ra;

    tbl[0]  = '{32'h00, 1'b0, 32'h0,        4'h0, ID,           1'b0, 0};
    tbl[1]  = '{32'h08, 1'b0, 32'h0,        4'h0, 32'h1,        1'b0, 0};
    tbl[2]  = '{32'h04, 1'b1, 32'h3,        4'hF, 32'h0,        1'b0, 0};
    tbl[3]  = '{32'h0C, 1'b1, 32'hDEADBEEF, 4'h5, 32'h0,        1'b0, 3};
    tbl[4]  = '{32'h0C, 1'b0, 32'h0,        4'h0, 32'h00AD00EF, 1'b0, 3};
    tbl[5]  = '{32'h40, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 3};
    tbl[6]  = '{32'h06, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 3};
    tbl[7]  = '{32'h08, 1'b0, 32'h0,        4'h0, 32'h7,        1'b0, 3};
    tbl[8]  = '{32'h00, 1'b1, 32'h1234,     4'hF, 32'h0,        1'b1, 3};
    tbl[9]  = '{32'h00, 1'b0, 32'h0,        4'h0, ID,           1'b0, 3};
    tbl[10] = '{32'h08, 1'b1, 32'h5,        4'hF, 32'h0,        1'b1, 3};
    tbl[11] = '{32'h04, 1'b1, 32'h0,        4'hE, 32'h0,        1'b0, 3};
    tbl[12] = '{32'h04, 1'b0, 32'h0,        4'h0, 32'h3,        1'b0, 3};
    tbl[13] = '{32'h04, 1'b1, 32'hF1,       4'hF, 32'h0,        1'b0, 3};
    tbl[14] = '{32'h04, 1'b0, 32'h0,        4'h0, 32'h1,        1'b0, 1};
    tbl[15] = '{32'h1C, 1'b1, 32'h11223344, 4'h8, 32'h0,        1'b0, 1};
    tbl[16] = '{32'h1C, 1'b0, 32'h0,        4'h0, 32'h11000000, 1'b0, 1};
    tbl[17] = '{32'h20, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1};
    tbl[18] = '{32'h1F, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1};
    tbl[19] = '{32'h04, 1'b1, 32'h0,        4'hF, 32'h0,        1'b0, 1};
    tbl[20] = '{32'h08, 1'b0, 32'h0,        4'h0, 32'd20,       1'b0, 0};

    rst = 1'b1; psel = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; pstrb = 0; pprot = 3'b001;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_prdata", prdata, 32'h0);
    chk("reset_pready", {31'd0, pready}, 32'd0);
    chk("reset_pslverr", {31'd0, pslverr}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      model(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].strb, 3'b001,
            mrd, mer, mws);
      xfer(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].strb, 3'b001,
           ard, aer, aws);
      chk($sformatf("tbl%0d_rdata", i), ard, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'd0, aer}, {31'd0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_waits", i), aws, tbl[i].exp_w);
    end

    // Protocol abort: psel drops after two access cycles.
    run("set_wait5", 32'h04, 1'b1, 32'h5, 4'hF, 3'b001);
    paddr = 32'h08; pwrite = 0; psel = 1; penable = 0;
    @(posedge clk); #1 penable = 1;
    seen = 0;
    repeat (2) begin @(negedge clk); seen |= pready; end
    @(posedge clk); #1 psel = 0; penable = 0;
    repeat (8) begin @(negedge clk); seen |= pready; end
    chk("abort_no_ready", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;
    run("after_abort_cnt", 32'h08, 1'b0, 32'h0, 4'h0, 3'b001);

    // Reset mid-write, then stray penable without setup.
    paddr = 32'h10; pwrite = 1; pwdata = 32'hFF; pstrb = 4'hF;
    psel = 1; penable = 0;
    @(posedge clk); #1 penable = 1;
    seen = 0;
    @(negedge clk); seen |= pready;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    model_reset();
    chk("midrst_pready", {31'd0, pready}, 32'd0);
    chk("midrst_prdata", prdata, 32'h0);
    repeat (8) begin @(negedge clk); seen |= pready; end
    chk("midrst_no_ready", {31'd0, seen}, 32'd0);
    @(posedge clk); #1 psel = 0; penable = 0;
    run("rst_scratch", 32'h10, 1'b0, 32'h0, 4'h0, 3'b001);
    run("rst_wait", 32'h04, 1'b0, 32'h0, 4'h0, 3'b001);
    run("rst_cnt", 32'h08, 1'b0, 32'h0, 4'h0, 3'b001);

    // Privilege on WAIT_CFG writes.
    run("prot_unpriv", 32'h04, 1'b1, 32'h2, 4'hF, 3'b000);
    run("prot_rd1", 32'h04, 1'b0, 32'h0, 4'h0, 3'b000);
    run("prot_priv", 32'h04, 1'b1, 32'h2, 4'hF, 3'b001);
    run("prot_rd2", 32'h04, 1'b0, 32'h0, 4'h0, 3'b000);
    run("prot_scratch", 32'h14, 1'b1, 32'hCAFE, 4'hF, 3'b000);
    run("prot_scr_rd", 32'h14, 1'b0, 32'h0, 4'h0, 3'b000);
    run("wrap_wait0", 32'h04, 1'b1, 32'h0, 4'hF, 3'b001);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, 40);
      else ra = $urandom_range(0, 9) * 4;
      run("rand", ra, 1'($urandom_range(0, 1)), $urandom,
          4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
